// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU sequencer: opcodes, FSM states,
// register-input mux selects and the opcode-to-strobe decode.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDA   = 4'h1;
    localparam logic [3:0] OP_LDB   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_MOVBA = 4'h4;
    localparam logic [3:0] OP_OUT   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;
    localparam logic [3:0] OP_JNC   = 4'h7;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [1:0] SEL_IMM = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_A   = 2'b10;

    typedef struct packed {
        logic [1:0] data_sel;
        logic       load_a;
        logic       load_b;
        logic       load_out;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{data_sel: SEL_IMM, load_a: 1'b0, load_b: 1'b0, load_out: 1'b0};

    // At most one strobe per opcode; opcodes without a strobe keep data_sel at SEL_IMM.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op);
        ctrl_t c;
        c = CTRL_IDLE;
        case (op)
            OP_LDA:   c.load_a = 1'b1;
            OP_LDB:   c.load_b = 1'b1;
            OP_ADD:   begin c.data_sel = SEL_ALU; c.load_a   = 1'b1; end
            OP_MOVBA: begin c.data_sel = SEL_A;   c.load_b   = 1'b1; end
            OP_OUT:   begin c.data_sel = SEL_A;   c.load_out = 1'b1; end
            default:  c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/program_counter.sv
// ADDR_W-bit program counter: load has priority over increment, wraps modulo 2^ADDR_W.
module program_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    always_comb begin
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Two-cycle fetch/execute controller. Strobes are decoded from the fetched
// word on the FETCH edge so they are registered yet high only during EXEC.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic [DATA_W-1:0] instr,
    input  logic              carry,
    output logic [ADDR_W-1:0] addr,
    output logic [3:0]        imm,
    output logic [1:0]        data_sel,
    output logic              load_a,
    output logic              load_b,
    output logic              load_out,
    output logic              halted
);

    state_t            state_d, state_q;
    logic [DATA_W-1:0] ir_d, ir_q;
    ctrl_t             ctrl_d, ctrl_q;
    logic              halted_d, halted_q;
    logic              pc_inc_s;
    logic              pc_load_s;
    logic [3:0]        op_s;
    logic [ADDR_W-1:0] jump_target_s;
    logic [ADDR_W-1:0] pc_s;

    assign op_s          = ir_q[7:4];
    assign jump_target_s = ADDR_W'(ir_q[3:0]);

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clock    (clock),
        .nReset   (nReset),
        .inc      (pc_inc_s),
        .load     (pc_load_s),
        .load_val (jump_target_s),
        .pc       (pc_s)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ctrl_d    = CTRL_IDLE;
        halted_d  = 1'b0;
        pc_inc_s  = 1'b0;
        pc_load_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                ir_d     = instr;
                pc_inc_s = 1'b1;
                ctrl_d   = decode_ctrl(instr[7:4]);
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                // JNC falls through with PC already advanced during FETCH.
                if (op_s == OP_JMP) begin
                    pc_load_s = 1'b1;
                end else if (op_s == OP_JNC) begin
                    pc_load_s = ~carry;
                end else begin
                    pc_load_s = 1'b0;
                end
                if (op_s == OP_HALT) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = ST_FETCH;
                end
            end
            ST_HALT: begin
                halted_d = 1'b1;
                state_d  = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q  <= ST_FETCH;
            ir_q     <= '0;
            ctrl_q   <= CTRL_IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            ctrl_q   <= ctrl_d;
            halted_q <= halted_d;
        end
    end

    assign addr     = pc_s;
    assign imm      = ir_q[3:0];
    assign data_sel = ctrl_q.data_sel;
    assign load_a   = ctrl_q.load_a;
    assign load_b   = ctrl_q.load_b;
    assign load_out = ctrl_q.load_out;
    assign halted   = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle expected outputs are queued
// alongside each program and compared at the falling clock edge.
module tb_cpu_sequencer;

    logic       clock;
    logic       nReset;
    logic [7:0] instr;
    logic       carry;
    logic [3:0] addr;
    logic [3:0] imm;
    logic [1:0] data_sel;
    logic       load_a;
    logic       load_b;
    logic       load_out;
    logic       halted;

    logic [7:0]  rom [16];
    logic [13:0] exp_q [$];
    int          n_vec;
    int          n_err;

    cpu_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clock    (clock),
        .nReset   (nReset),
        .instr    (instr),
        .carry    (carry),
        .addr     (addr),
        .imm      (imm),
        .data_sel (data_sel),
        .load_a   (load_a),
        .load_b   (load_b),
        .load_out (load_out),
        .halted   (halted)
    );

    assign instr = rom[addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input logic [3:0] a, input logic [3:0] i, input logic [1:0] s,
                        input logic la, input logic lb, input logic lo, input logic h);
        exp_q.push_back({a, i, s, la, lb, lo, h});
    endtask

    task automatic pf(input logic [3:0] a, input logic [3:0] i);
        push(a, i, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ph(input logic [3:0] a);
        push(a, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string tag);
        logic [13:0] obs;
        logic [13:0] exp_v;
        obs = {addr, imm, data_sel, load_a, load_b, load_out, halted};
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: observed %h but scoreboard empty (required an entry)", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_err++;
                $error("FAIL %s: observed {addr,imm,sel,la,lb,lo,halt}=%h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic step(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check(tag);
            @(negedge clock);
        end
    endtask

    // Hold reset for 20 ns over a randomised ROM, then check the reset outputs.
    task automatic apply_reset(input string tag);
        nReset = 1'b0;
        for (int j = 0; j < 16; j++) rom[j] = 8'($urandom);
        repeat (2) @(negedge clock);
        pf(4'h0, 4'h0);
        check(tag);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        nReset = 1'b0;
        carry  = 1'b0;

        // LDA 5, LDB 3, ADD, OUT, HALT
        apply_reset("reset_initial");
        rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h30; rom[3] = 8'h50; rom[4] = 8'hF0;
        nReset = 1'b1;
        pf(4'd0, 4'd0);
        push(4'd1, 4'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        pf(4'd1, 4'd5);
        push(4'd2, 4'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        pf(4'd2, 4'd3);
        push(4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        pf(4'd3, 4'd0);
        push(4'd4, 4'd0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        pf(4'd4, 4'd0);
        pf(4'd5, 4'd0);
        repeat (3) ph(4'd5);
        step(13, "lda_ldb_add_out");

        // NOP, undefined opcode 9, JMP 10, HALT at 10
        apply_reset("reset_jmp");
        rom[0] = 8'h00; rom[1] = 8'h9C; rom[2] = 8'h6A; rom[10] = 8'hF0;
        nReset = 1'b1;
        pf(4'd0, 4'd0);  pf(4'd1, 4'd0);
        pf(4'd1, 4'd0);  pf(4'd2, 4'd12);
        pf(4'd2, 4'd12); pf(4'd3, 4'd10);
        pf(4'd10, 4'd10); pf(4'd11, 4'd0);
        ph(4'd11);
        step(9, "jmp");

        // JNC 4 with carry set: falls through
        apply_reset("reset_jnc_c1");
        rom[0] = 8'h74; rom[1] = 8'hF0; rom[4] = 8'hF0;
        carry  = 1'b1;
        nReset = 1'b1;
        pf(4'd0, 4'd0); pf(4'd1, 4'd4); pf(4'd1, 4'd4); pf(4'd2, 4'd0); ph(4'd2);
        step(5, "jnc_carry1");

        // JNC 4 with carry clear: taken
        apply_reset("reset_jnc_c0");
        rom[0] = 8'h74; rom[1] = 8'hF0; rom[4] = 8'hF0;
        carry  = 1'b0;
        nReset = 1'b1;
        pf(4'd0, 4'd0); pf(4'd1, 4'd4); pf(4'd4, 4'd4); pf(4'd5, 4'd0); ph(4'd5);
        step(5, "jnc_carry0");

        // JNC 14 taken, NOPs at 14/15 wrap to 0, JNC not taken, JMP 7, HALT at 7
        apply_reset("reset_wrap");
        rom[0] = 8'h7E; rom[14] = 8'h00; rom[15] = 8'h00; rom[1] = 8'h67; rom[7] = 8'hF0;
        carry  = 1'b0;
        nReset = 1'b1;
        pf(4'd0, 4'd0);  pf(4'd1, 4'd14);
        pf(4'd14, 4'd14); pf(4'd15, 4'd0);
        pf(4'd15, 4'd0); pf(4'd0, 4'd0);
        pf(4'd0, 4'd0);
        step(7, "wrap");
        carry = 1'b1;
        pf(4'd1, 4'd14); pf(4'd1, 4'd14);
        pf(4'd2, 4'd7);  pf(4'd7, 4'd7);
        pf(4'd8, 4'd0);
        repeat (10) ph(4'd8);
        step(15, "halt_hold");

        // Async reset in the middle of an LDA EXEC
        apply_reset("reset_async_pre");
        rom[0] = 8'h15;
        carry  = 1'b0;
        nReset = 1'b1;
        pf(4'd0, 4'd0);
        step(1, "async_fetch");
        push(4'd1, 4'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("async_exec");
        #1 nReset = 1'b0;
        #1 pf(4'd0, 4'd0);
        check("async_reset");
        apply_reset("reset_async_hold");
        rom[0] = 8'h15;
        nReset = 1'b1;
        pf(4'd0, 4'd0);
        push(4'd1, 4'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2, "async_restart");

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/execute controller for the 8-bit CPU. It sits directly upstream of the 8-bit load-enable registers (A, B, OUT).
- Owns the program counter and instruction register. It reads an 8-bit instruction from program ROM and drives the one-cycle load strobes and the data-mux select that the registers consume.
- Every instruction takes 2 cycles (FETCH, EXEC). HALT parks the sequencer until reset.

Parameters:
- ADDR_W, 4, program counter / ROM address width (16 words); jump targets are imm zero-extended to ADDR_W.
- DATA_W, 8, instruction and datapath width.

Ports:
- clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- instr  input  DATA_W  ROM read data; combinational from addr, valid in FETCH.
- carry  input  1  ALU carry flag, sampled in EXEC.
- addr  output  ADDR_W  ROM address (= PC).
- imm  output  4  instruction immediate field IR[3:0].
- data_sel  output  2  register input mux select: 00 imm (zero-extended), 01 ALU sum, 10 A register, 11 reserved.
- load_a  output  1  load strobe, register A.
- load_b  output  1  load strobe, register B.
- load_out  output  1  load strobe, output register.
- halted  output  1  high while in HALT.

Behaviour:
- Reset is async, active-low. It applies to outputs and internal state:
  - state=FETCH, PC=0, IR=0.
  - All load strobes 0, data_sel=00, halted=0.
  - Reset mid-instruction aborts that instruction; no strobe is issued after nReset rises until the next EXEC.
- Instruction format: op=IR[7:4], imm=IR[3:0].
- FETCH, one cycle:
  - addr=PC.
  - On the clock edge: IR<=instr, PC<=PC+1 (mod 2^ADDR_W; 15 wraps to 0), state<=EXEC.
  - Strobes are 0.
- EXEC, one cycle:
  - Strobes are combinational from IR and high for exactly this cycle, so the target register captures on the edge ending EXEC.
  - Next state is FETCH unless noted.
- Opcodes:
  - 0000 NOP: no strobe.
  - 0001 LDA: data_sel=00, load_a=1.
  - 0010 LDB: data_sel=00, load_b=1.
  - 0011 ADD: data_sel=01, load_a=1 (A<=A+B; carry produced by ALU).
  - 0100 MOVBA: data_sel=10, load_b=1.
  - 0101 OUT: data_sel=10, load_out=1.
  - 0110 JMP: PC<=imm at end of EXEC.
  - 0111 JNC: if carry==0 then PC<=imm, else PC is unchanged (already +1). carry is sampled on the EXEC edge only.
  - 1111 HALT: next state HALT.
  - Any other opcode: treated as NOP.
- HALT state:
  - halted=1; strobes 0; PC and IR frozen; addr holds the PC value after the HALT fetch.
  - Exit only via nReset.
- Only one strobe is ever high in a cycle.
- data_sel is 00 in every state or opcode that asserts no strobe.
- JMP to the HALT's own address and JMP to self are legal (infinite loop).

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP … OP_HALT)
  - state encoding (ST_FETCH, ST_EXEC, ST_HALT)
  - data_sel encodings (SEL_IMM, SEL_ALU, SEL_A)
- One natural sub-module: program_counter (ADDR_W-bit counter with inc, load, load value, async active-low reset).
- Decode stays in the sequencer.

Test Plan:
- Reset: hold nReset=0 for 20 ns with random instr -> addr=0, all strobes 0, halted=0. After release, the first FETCH reads addr 0.
- Sequence LDA 5 (0x15), LDB 3 (0x23), ADD (0x30), OUT (0x50) ->
  - load_a high in cycle 2 with data_sel=00, imm=5
  - load_b high in cycle 4
  - load_a with data_sel=01 in cycle 6
  - load_out with data_sel=10 in cycle 8
  - addr steps 0,1,2,3
- JMP 0x6A at addr 2 -> next FETCH addr=10, no strobes during the JMP EXEC.
- JNC 0x74: with carry=1 -> next addr = PC+1; with carry=0 -> next addr=4.
- Wrap and HALT:
  - NOP at addr 15 -> next addr=0.
  - HALT 0xF0 at addr 7 -> halted=1 from the cycle after EXEC, addr stays 8 for 10 cycles, strobes stay 0.
- Async reset asserted mid-EXEC of LDA -> load_a drops immediately, state returns to FETCH, addr=0.
